// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the connection-block configuration loader.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;

  // Config width of one connection_block: output-pin taps plus input-pin taps onto the tracks.
  function automatic int cb_cfg_width(input int clbout0, input int clbos, input int clbod,
                                      input int clbin0, input int ws, input int wd, input int wg,
                                      input int clbx, input int clbout1, input int clbin1);
    return clbout0 * (clbos + clbod)
         + clbin0 * (ws + wd + wg + clbx * clbout1)
         + clbin1 * (ws + wd);
  endfunction

  localparam int CB_CW_DEFAULT = cb_cfg_width(2, 4, 4, 4, 8, 4, 1, 1, 2, 1);

endpackage

// File: rtl/cb_cfg_shadow.sv
// Word-addressed shadow register that collects a configuration frame before commit.
module cb_cfg_shadow #(
  parameter int DW = 8,
  parameter int NW = 11,
  parameter int IW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IW-1:0]    widx_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [NW*DW-1:0] shadow_o
);

  logic [NW-1:0][DW-1:0] shadow_q;

  // NOTE: this storage is reset on purpose so a commit after power-up can never drive X onto the switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we_i && (widx_i == IW'(k))) begin
          shadow_q[k] <= wdata_i;
        end
      end
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/cb_config_loader.sv
// Word-serial loader for one connection_block: fills a shadow register, then commits it to c_out atomically.
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int CW = CB_CW_DEFAULT,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_clear,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_valid,
  input  logic          cfg_last,
  output logic          cfg_ready,
  output logic [CW-1:0] c_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int NW = (CW + DW - 1) / DW;
  localparam int WW = $clog2(NW + 1);

  cfg_state_e        state_q, state_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     c_out_q, c_out_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              done_q, done_d;
  logic [NW*DW-1:0]  shadow_w;
  logic              hs;
  logic              at_end;
  logic              shadow_we;

  assign hs        = cfg_valid & cfg_ready;
  assign at_end    = (wcnt_q == WW'(NW - 1));
  assign shadow_we = (state_q == LOAD) & hs & ~cfg_clear;

  cb_cfg_shadow #(
    .DW (DW),
    .NW (NW),
    .IW (WW)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (shadow_we),
    .widx_i   (wcnt_q),
    .wdata_i  (cfg_data),
    .shadow_o (shadow_w)
  );

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (cfg_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (cfg_start) state_d = LOAD;
        LOAD: begin
          if (hs) begin
            if (cfg_last)    state_d = at_end ? COMMIT : IDLE;
            else if (at_end) state_d = DRAIN;
          end
        end
        DRAIN:  if (hs && cfg_last) state_d = IDLE;
        COMMIT: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state_q == LOAD) || (state_q == DRAIN);
    busy      = (state_q != IDLE);
  end

  // Datapath next state: word counter, active vector, error flags and the commit pulse.
  always_comb begin
    wcnt_d  = wcnt_q;
    c_out_d = c_out_q;
    err_d   = err_q;
    code_d  = code_q;
    done_d  = 1'b0;
    if (cfg_clear) begin
      wcnt_d  = '0;
      c_out_d = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            wcnt_d = '0;
            err_d  = 1'b0;
            code_d = ERR_NONE;
          end
        end
        LOAD: begin
          if (hs) begin
            wcnt_d = wcnt_q + WW'(1);
            if (cfg_last && !at_end) begin
              err_d  = 1'b1;
              code_d = ERR_SHORT;
            end else if (!cfg_last && at_end) begin
              err_d  = 1'b1;
              code_d = ERR_LONG;
            end
          end
        end
        COMMIT: begin
          c_out_d = shadow_w[CW-1:0];
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      c_out_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      c_out_q <= c_out_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign c_out    = c_out_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_cb_config_loader.sv
// Self-checking bench for cb_config_loader: frame table, hand-written corner sequences and random frames.
module tb_cb_config_loader;

  localparam int CW = 88;
  localparam int DW = 8;
  localparam int NW = (CW + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_clear = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_last = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] c_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the vector that should currently be driven onto the connection block.
  logic [CW-1:0] exp_c = '0;

  cb_config_loader #(.CW(CW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_clear (cfg_clear),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .c_out     (c_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         len;
    logic [1:0] code;
    bit         gaps;
    logic [7:0] pat;
    int         clear_at;
    int         mid_start;
  } vec_t;

  // Drives one frame of len words, checks every observable consequence against the model.
  // clear_at: word index at which cfg_clear aborts the load (NW = coincident with COMMIT), -1 none.
  task automatic run_frame(input int len, input logic [1:0] exp_code, input bit gaps,
                           input logic [7:0] pat, input int clear_at, input int mid_start);
    logic [7:0]       words [NW];
    logic [NW*DW-1:0] img;
    logic [7:0]       w;
    int               i;
    int               cycles;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    check("start_code", err_code, 0);
    i = 0;
    cycles = 0;
    while (i < len) begin
      cycles++;
      if (cycles > 400) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_timeout: got %0d words expected %0d", i, len);
        break;
      end
      if (clear_at == i) begin
        cfg_clear = 1'b1;
        @(posedge clk); #1 cfg_clear = 1'b0;
        exp_c = '0;
        check("clear_load_c", c_out, exp_c);
        check("clear_load_busy", busy, 0);
        check("clear_load_err", err, 0);
        check("clear_load_done", done, 0);
        check("clear_load_ready", cfg_ready, 0);
        return;
      end
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        check("gap_hold_c", c_out, exp_c);
        continue;
      end
      w = (pat != 8'h00) ? pat : 8'($urandom);
      cfg_valid = 1'b1;
      cfg_data  = w;
      cfg_last  = (i == len - 1);
      cfg_start = (i == mid_start);
      check("ready_in_frame", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_start = 1'b0;
      if (i < NW) words[i] = w;
      i++;
      if (i == NW && len > NW) begin
        check("long_err", err, 1);
        check("long_code", err_code, 2);
        check("long_drain_busy", busy, 1);
      end
      if (i < len) begin
        check("frame_hold_c", c_out, exp_c);
        check("frame_no_done", done, 0);
      end
    end
    if (exp_code == 2'd0) begin
      check("commit_pre_done", done, 0);
      check("commit_pre_c", c_out, exp_c);
      check("commit_pre_busy", busy, 1);
      if (clear_at == NW) begin
        cfg_clear = 1'b1;
        @(posedge clk); #1 cfg_clear = 1'b0;
        exp_c = '0;
        check("clear_commit_done", done, 0);
        check("clear_commit_c", c_out, exp_c);
        check("clear_commit_busy", busy, 0);
      end else begin
        img = '0;
        for (int k = 0; k < NW; k++) img[k*DW +: DW] = words[k];
        exp_c = img[CW-1:0];
        @(posedge clk); #1;
        check("commit_done", done, 1);
        check("commit_c", c_out, exp_c);
        check("commit_busy", busy, 0);
        check("commit_err", err, 0);
        @(posedge clk); #1;
        check("commit_done_pulse", done, 0);
      end
    end else begin
      check("bad_err", err, 1);
      check("bad_code", err_code, exp_code);
      check("bad_busy", busy, 0);
      check("bad_keep_c", c_out, exp_c);
      check("bad_no_done", done, 0);
    end
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{11, 2'd0, 1'b0, 8'hA5, -1, -1};
    tbl[1]  = '{6,  2'd1, 1'b0, 8'h00, -1, -1};
    tbl[2]  = '{13, 2'd2, 1'b0, 8'h00, -1, -1};
    tbl[3]  = '{11, 2'd0, 1'b1, 8'h00, -1,  5};
    tbl[4]  = '{11, 2'd0, 1'b1, 8'hA5, -1, -1};
    tbl[5]  = '{1,  2'd1, 1'b1, 8'h00, -1, -1};
    tbl[6]  = '{12, 2'd2, 1'b1, 8'h00, -1, -1};
    tbl[7]  = '{11, 2'd0, 1'b0, 8'h00,  4, -1};
    tbl[8]  = '{11, 2'd0, 1'b0, 8'h00, -1, -1};
    tbl[9]  = '{11, 2'd0, 1'b0, 8'h00, NW, -1};
    tbl[10] = '{11, 2'd0, 1'b1, 8'h00, -1, -1};

    #1;
    check("reset_c", c_out, 0);
    check("reset_ready", cfg_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_code", err_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 11; t++) begin
      run_frame(tbl[t].len, tbl[t].code, tbl[t].gaps, tbl[t].pat, tbl[t].clear_at, tbl[t].mid_start);
    end

    // Start and clear together: clear wins, sticky error is cleared, no load begins.
    run_frame(3, 2'd1, 1'b0, 8'h00, -1, -1);
    @(posedge clk); #1;
    check("err_sticky", err, 1);
    cfg_start = 1'b1;
    cfg_clear = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_clear = 1'b0;
    exp_c = '0;
    check("start_clear_busy", busy, 0);
    check("start_clear_err", err, 0);
    check("start_clear_code", err_code, 0);
    check("start_clear_c", c_out, exp_c);
    @(posedge clk); #1;
    check("start_clear_ready", cfg_ready, 0);

    // Asynchronous reset in the middle of a load after a committed vector.
    run_frame(11, 2'd0, 1'b0, 8'h00, -1, -1);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_c = '0;
    check("midreset_c", c_out, exp_c);
    check("midreset_busy", busy, 0);
    check("midreset_ready", cfg_ready, 0);
    check("midreset_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random frames: expected outcome derived purely from the frame length.
    for (int r = 0; r < 15; r++) begin
      int         len;
      logic [1:0] code;
      len  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : NW;
      code = (len < NW) ? 2'd1 : ((len > NW) ? 2'd2 : 2'd0);
      run_frame(len, code, 1'b1, 8'h00, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
